// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and the memory it fronts.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 7;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; master is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::MEM_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_trigWrite;
  logic              mem_trigRead;
  logic [DATA_W-1:0] mem_readData;
  logic              busy;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_readData,
    output if_ack, if_rdata, d_ack, d_rdata, mem_address, mem_writeData,
           mem_trigWrite, mem_trigRead, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_readData,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_address, mem_writeData,
           mem_trigWrite, mem_trigRead, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Grant decision: data wins ties unless its streak has starved fetch long enough.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   streak_full,
  output owner_t owner,
  output logic   valid
);

  always_comb begin
    owner = OWN_IF;
    valid = if_req | d_req;
    if (d_req && !(if_req && streak_full)) owner = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port sequencer in front of the single-ported memory: arbitrates fetch vs
// load/store, generates trig strobes around stable address/data, returns acks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = MEM_ADDR_W,
  parameter int unsigned DATA_W          = MEM_DATA_W,
  parameter int unsigned TRIG_CYCLES     = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int unsigned STK_W = $clog2(MAX_DATA_STREAK + 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  owner_t            own, own_n;
  logic              we, we_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] wdata, wdata_n;
  logic [DATA_W-1:0] rdata, rdata_n;
  logic [STK_W-1:0]  streak, streak_n;
  logic              if_ack, if_ack_n, d_ack, d_ack_n;
  logic              trig_rd, trig_rd_n, trig_wr, trig_wr_n;
  logic              busy, busy_n;

  owner_t pick_owner;
  logic   pick_valid;
  logic   streak_full;

  assign streak_full = (streak == STK_W'(MAX_DATA_STREAK));

  mem_arb_pick u_pick (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .streak_full (streak_full),
    .owner       (pick_owner),
    .valid       (pick_valid)
  );

  // Next state, transaction latches, and next values of the registered outputs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    own_n    = own;
    we_n     = we;
    addr_n   = addr;
    wdata_n  = wdata;
    rdata_n  = rdata;
    streak_n = streak;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_n = ST_PULSE;
          cnt_n   = '0;
          own_n   = pick_owner;
          if (pick_owner == OWN_D) begin
            addr_n   = bus.d_addr;
            we_n     = bus.d_we;
            wdata_n  = bus.d_wdata;
            streak_n = !bus.if_req ? '0 :
                       (streak_full ? streak : streak + STK_W'(1));
          end else begin
            addr_n   = bus.if_addr;
            we_n     = 1'b0;
            streak_n = '0;
          end
        end
      end
      ST_PULSE: begin
        if (cnt == CNT_W'(TRIG_CYCLES - 1)) state_n = ST_SAMPLE;
        else                                cnt_n   = cnt + CNT_W'(1);
      end
      ST_SAMPLE: begin
        state_n = ST_RESP;
        if (!we) rdata_n = bus.mem_readData;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n    = (state_n != ST_IDLE);
    trig_rd_n = (state_n == ST_PULSE) && !we_n;
    trig_wr_n = (state_n == ST_PULSE) &&  we_n;
    if_ack_n  = (state_n == ST_RESP) && (own_n == OWN_IF);
    d_ack_n   = (state_n == ST_RESP) && (own_n == OWN_D);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      own     <= OWN_IF;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      streak  <= '0;
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      trig_rd <= 1'b0;
      trig_wr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      own     <= own_n;
      we      <= we_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      rdata   <= rdata_n;
      streak  <= streak_n;
      if_ack  <= if_ack_n;
      d_ack   <= d_ack_n;
      trig_rd <= trig_rd_n;
      trig_wr <= trig_wr_n;
      busy    <= busy_n;
    end
  end

  assign bus.if_ack        = if_ack;
  assign bus.d_ack         = d_ack;
  assign bus.if_rdata      = rdata;
  assign bus.d_rdata       = rdata;
  assign bus.mem_address   = addr;
  assign bus.mem_writeData = wdata;
  assign bus.mem_trigRead  = trig_rd;
  assign bus.mem_trigWrite = trig_wr;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter (TRIG_CYCLES=1 and TRIG_CYCLES=3 instances).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus3 ();

  mem_arbiter #(.ADDR_W(7), .DATA_W(32), .TRIG_CYCLES(1), .MAX_DATA_STREAK(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));
  mem_arbiter #(.ADDR_W(7), .DATA_W(32), .TRIG_CYCLES(3), .MAX_DATA_STREAK(4)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.master));

  // Behavioural memories with a bench-side preload port.
  logic [31:0] mem1 [128];
  logic [31:0] mem3 [128];
  logic        pre_we1 = 1'b0, pre_we3 = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we1) mem1[pre_addr] <= pre_data;
    else if (bus1.mem_trigWrite) mem1[bus1.mem_address] <= bus1.mem_writeData;
  end
  always @(posedge clk) begin
    if (pre_we3) mem3[pre_addr] <= pre_data;
    else if (bus3.mem_trigWrite) mem3[bus3.mem_address] <= bus3.mem_writeData;
  end
  assign bus1.mem_readData = mem1[bus1.mem_address];
  assign bus3.mem_readData = mem3[bus3.mem_address];

  typedef struct {
    bit          is_if;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [128];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ack monitor for the TRIG_CYCLES=1 instance: order, owner and read data.
  always @(negedge clk) begin
    if (!reset && (bus1.if_ack || bus1.d_ack)) begin
      exp_t e;
      chk("ack_exclusive", 32'(bus1.if_ack & bus1.d_ack), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_owner", 32'(bus1.if_ack), 32'(e.is_if));
        if (e.is_rd) chk("sb_rdata", bus1.if_ack ? bus1.if_rdata : bus1.d_rdata, e.data);
      end
    end
  end

  task automatic preload1(input logic [6:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we1 = 1'b1;
    @(negedge clk);
    pre_we1 = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic run_d(input logic w, input logic [6:0] a, input logic [31:0] wd,
                       output int lat, output int ntrig, output int first, output int bad);
    exp_t e;
    bus1.d_req = 1'b1; bus1.d_we = w; bus1.d_addr = a; bus1.d_wdata = wd;
    e.is_if = 1'b0; e.is_rd = !w; e.data = w ? 32'd0 : model_mem[a];
    sb.push_back(e);
    if (w) model_mem[a] = wd;
    lat = 0; ntrig = 0; first = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (w ? bus1.mem_trigWrite : bus1.mem_trigRead) begin
        ntrig++;
        if (first == 0) first = k;
      end
      if (w ? bus1.mem_trigRead : bus1.mem_trigWrite) bad++;
      if (bus1.d_ack) begin lat = k; break; end
    end
    bus1.d_req = 1'b0;
  endtask

  task automatic run_if(input logic [6:0] a, output int lat, output int dacks);
    exp_t e;
    bus1.if_req = 1'b1; bus1.if_addr = a;
    e.is_if = 1'b1; e.is_rd = 1'b1; e.data = model_mem[a];
    sb.push_back(e);
    lat = 0; dacks = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus1.d_ack) dacks++;
      if (bus1.if_ack) begin lat = k; break; end
    end
    bus1.if_req = 1'b0;
  endtask

  initial begin
    int lat, ntrig, first, bad, dacks, d_at, i_at, dcnt, icnt, acks, abad;
    logic [5:0] seq;
    exp_t e;

    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = '0;   bus3.d_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_outs", 32'({bus1.if_ack, bus1.d_ack, bus1.mem_trigRead, bus1.mem_trigWrite}), 32'd0);
    chk("rst_addr", 32'(bus1.mem_address), 32'd0);
    chk("rst_wdata", bus1.mem_writeData, 32'd0);
    chk("rst_rdata", bus1.d_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Data write then read-back.
    run_d(1'b1, 7'd5, 32'hABCDABCD, lat, ntrig, first, bad);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_ntrig", 32'(ntrig), 32'd1);
    chk("wr_first", 32'(first), 32'd1);
    chk("wr_other_strobe", 32'(bad), 32'd0);
    @(negedge clk);
    chk("wr_mem5", mem1[5], 32'hABCDABCD);
    run_d(1'b0, 7'd5, 32'd0, lat, ntrig, first, bad);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_ntrig", 32'(ntrig), 32'd1);
    chk("rd_other_strobe", 32'(bad), 32'd0);
    @(negedge clk);

    // Fetch read of a preloaded word.
    preload1(7'd2, 32'hBBBBCCCC);
    run_if(7'd2, lat, dacks);
    chk("if_lat", 32'(lat), 32'd3);
    chk("if_no_dack", 32'(dacks), 32'd0);
    @(negedge clk);

    // Simultaneous requests: data first, then fetch.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 7'd5;
    bus1.if_req = 1'b1; bus1.if_addr = 7'd2;
    e.is_if = 1'b0; e.is_rd = 1'b1; e.data = model_mem[5]; sb.push_back(e);
    e.is_if = 1'b1; e.is_rd = 1'b1; e.data = model_mem[2]; sb.push_back(e);
    d_at = 0; i_at = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus1.d_ack)  begin d_at = k; bus1.d_req  = 1'b0; end
      if (bus1.if_ack) begin i_at = k; bus1.if_req = 1'b0; end
      if (d_at != 0 && i_at != 0) break;
    end
    bus1.d_req = 1'b0; bus1.if_req = 1'b0;
    chk("sim_d_at", 32'(d_at), 32'd3);
    chk("sim_if_at", 32'(i_at), 32'd7);
    @(negedge clk);

    // Starvation guard: four data grants, one fetch, then data resumes.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 7'd5;
    bus1.if_req = 1'b1; bus1.if_addr = 7'd2;
    for (int i = 0; i < 6; i++) begin
      e.is_if = (i == 4); e.is_rd = 1'b1; e.data = (i == 4) ? model_mem[2] : model_mem[5];
      sb.push_back(e);
    end
    dcnt = 0; icnt = 0; seq = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus1.d_ack) begin
        dcnt++; seq = {seq[4:0], 1'b1};
        if (dcnt == 5) bus1.d_req = 1'b0;
      end
      if (bus1.if_ack) begin
        icnt++; seq = {seq[4:0], 1'b0};
        bus1.if_req = 1'b0;
      end
      if (dcnt >= 5 && icnt >= 1) break;
    end
    bus1.d_req = 1'b0; bus1.if_req = 1'b0;
    chk("stv_seq", 32'(seq), 32'b111101);
    chk("stv_dcnt", 32'(dcnt), 32'd5);
    chk("stv_icnt", 32'(icnt), 32'd1);
    @(negedge clk);

    // Reset during PULSE of a read: everything drops, no ack follows.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 7'd2;
    @(negedge clk);
    chk("rm_trig", 32'(bus1.mem_trigRead), 32'd1);
    reset = 1'b1; bus1.d_req = 1'b0;
    @(negedge clk);
    chk("rm_outs", 32'({bus1.if_ack, bus1.d_ack, bus1.mem_trigRead, bus1.mem_trigWrite}), 32'd0);
    chk("rm_busy", 32'(bus1.busy), 32'd0);
    chk("rm_rdata", bus1.d_rdata, 32'd0);
    reset = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus1.d_ack || bus1.if_ack) acks++;
    end
    chk("rm_no_ack", 32'(acks), 32'd0);

    // TRIG_CYCLES=3 instance: three-cycle strobe, stable address, ack at cycle 5.
    pre_addr = 7'd9; pre_data = 32'h13572468; pre_we3 = 1'b1;
    @(negedge clk);
    pre_we3 = 1'b0;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 7'd9;
    lat = 0; ntrig = 0; bad = 0; abad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus3.mem_trigRead)  ntrig++;
      if (bus3.mem_trigWrite) bad++;
      if (bus3.busy && bus3.mem_address !== 7'd9) abad++;
      if (bus3.d_ack) begin lat = k; break; end
    end
    chk("t3_rdata", bus3.d_rdata, 32'h13572468);
    bus3.d_req = 1'b0;
    chk("t3_lat", 32'(lat), 32'd5);
    chk("t3_ntrig", 32'(ntrig), 32'd3);
    chk("t3_addr_stable", 32'(abad), 32'd0);
    chk("t3_no_write", 32'(bad), 32'd0);
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and two-port arbiter sitting in front of the single-ported `memory` block of the MIPS simulation CPU. It shares the memory between the instruction-fetch requester (read-only) and the load/store requester (read/write). It generates the `trigRead`/`trigWrite` pulses with stable address and data around them, captures `readData`, and returns a one-cycle acknowledge. Data accesses have priority, and a streak counter prevents fetch starvation.

## Interface
Parameters:
- `ADDR_W`, 7, word address width (matches memory).
- `DATA_W`, 32, data width.
- `TRIG_CYCLES`, 1, cycles a trig strobe is held high (≥1).
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while fetch is waiting (≥1).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; already decided.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle fetch completion.
- `if_rdata` out DATA_W: fetched word; valid when `if_ack`=1.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1=write, 0=read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_ack` out 1: one-cycle data completion.
- `d_rdata` out DATA_W: load word; valid when `d_ack`=1 and `d_we`=0.
- `mem_address` out ADDR_W: to memory `address`.
- `mem_writeData` out DATA_W: to memory `writeData`.
- `mem_trigWrite` out 1: to memory `trigWrite`.
- `mem_trigRead` out 1: to memory `trigRead`.
- `mem_readData` in DATA_W: from memory `readData`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, PULSE, SAMPLE, RESP.
  - IDLE → PULSE when any request is granted.
  - PULSE → SAMPLE after TRIG_CYCLES cycles.
  - SAMPLE → RESP.
  - RESP → IDLE, always.
- Arbitration happens only in IDLE:
  - Only one requester active: it wins.
  - Both active: data wins, unless `streak` == MAX_DATA_STREAK; then fetch wins.
- Streak counter:
  - Incremented on a data grant while `if_req`=1.
  - Cleared on a fetch grant, and on a data grant with `if_req`=0.
  - Saturates at MAX_DATA_STREAK.
- At grant, the arbiter latches owner, address, write flag and write data.
  - `mem_address` and `mem_writeData` come from these latches.
  - They stay stable from the first PULSE cycle through SAMPLE.
  - Outside a transaction they hold their last values.
- PULSE: `mem_trigRead` (read) or `mem_trigWrite` (write) is high for exactly TRIG_CYCLES cycles. The two strobes are never high together.
- SAMPLE: strobes low. For reads, `mem_readData` is registered into a shared read register at the end of the cycle.
- RESP: the owner's ack is high for one cycle.
  - `if_rdata` and `d_rdata` both drive the shared read register.
  - The register holds its value until the next read.
- A requester must not change its address, write flag or write data while its req is high and ack has not yet been seen.
- A req still high in the IDLE cycle after RESP is treated as a new request.
- Reset values: all ack/strobe outputs 0, `busy`=0, `mem_address`=0, `mem_writeData`=0, read register 0, `streak`=0, state IDLE.
- Reset mid-transaction:
  - Strobes and acks are low from the next cycle; no ack is ever issued for the aborted access.
  - A write aborted during PULSE may or may not have reached memory.

## Timing
- Request seen in IDLE at cycle 0; PULSE occupies cycles 1..TRIG_CYCLES; SAMPLE is at T+1; ack at T+2.
- Request-to-ack latency is TRIG_CYCLES+2 cycles. The default is 3.
- Throughput: one access per TRIG_CYCLES+3 cycles, because IDLE costs one cycle between transactions.
- Requests arriving while `busy`=1 are only evaluated at the next IDLE.
- The ack and the read data are registered outputs. No input reaches an output combinationally.

## Structure
- Package `mem_arb_pkg` holds:
  - the FSM state enum;
  - owner constants OWN_IF and OWN_D;
  - default ADDR_W/DATA_W localparams shared with the `memory` instance.
- Sub-module `mem_arb_pick`: combinational grant decision with inputs `if_req`, `d_req`, `streak_full` and output owner/valid.
- Everything else, including the FSM, counters and latches, lives in `mem_arbiter`.

## Test plan
- Data write, then read:
  - Write `d_addr`=5, `d_wdata`=32'hABCDABCD. Expect `mem_trigWrite` high exactly cycle 1 and `d_ack` at cycle 3; `memoryFile[5]` equals ABCDABCD.
  - Then read address 5. Expect `d_rdata`=32'hABCDABCD with `d_ack`.
- Fetch read: preload `memoryFile[2]`=32'hBBBBCCCC, assert `if_req`, `if_addr`=2. Expect `if_ack` 3 cycles later with `if_rdata`=BBBBCCCC; `d_ack` stays 0.
- Simultaneous requests: `if_req` and `d_req` asserted together in IDLE. Expect data served first, then fetch; the two acks are never in the same cycle.
- Starvation guard: hold `d_req` continuously (reads) with `if_req` high, MAX_DATA_STREAK=4. Expect 4 data acks, then 1 fetch ack, then data resumes.
- Reset mid-access: assert `reset` during PULSE of a read. Next cycle all strobes, acks and `busy` are 0, the read register is 0, and no ack follows.
- TRIG_CYCLES=3: a read holds `mem_trigRead` high for exactly 3 cycles, `mem_address` is stable throughout, and the ack comes at cycle 5.
